// File: rtl/bg_arb_pkg.sv
// Shared types and constants for the background tile-RAM write arbiter.
package bg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  localparam int unsigned TILE_COLS  = 40;
  localparam int unsigned TILE_ROWS  = 30;
  localparam int unsigned TILE_COUNT = TILE_COLS * TILE_ROWS;

  localparam int unsigned REQ_SCORE  = 0;
  localparam int unsigned REQ_GROUND = 1;
  localparam int unsigned REQ_COIN   = 2;
  localparam int unsigned REQ_TEXT   = 3;
  localparam int unsigned REQ_GHOST  = 4;
  localparam int unsigned REQ_SPARE  = 5;

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above the pointer, with wrap.
module rr_pick
  import bg_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 6,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % N_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/bg_write_arbiter.sv
// Round-robin owner of the background tile-RAM write port, with a built-in
// full-map zero-fill engine that takes priority over new bursts.
module bg_write_arbiter
  import bg_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 6,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TILE_COUNT = bg_arb_pkg::TILE_COUNT,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  input  logic                    clear_start,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    clear_busy,
  output logic [ADDR_W-1:0]       bg_ram_addr,
  output logic [DATA_W-1:0]       bg_ram_data,
  output logic                    bg_wea
);

  localparam int unsigned IDX_W = idx_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              pend_q, pend_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [N_REQ-1:0]  ack_c;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              burst_end;
  logic [CNT_W-1:0]  cnt_inc;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next state; while granted, ptr_q doubles as the owner index.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    wea_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    ack_c      = '0;
    burst_end  = 1'b0;

    if (clear_start && (state_q != CLEAR)) begin
      pend_d = 1'b1;
    end

    if (en) begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_d = CLEAR;
          end else if (|req) begin
            grant_d = pick_gnt;
            ptr_d   = pick_idx;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (req[ptr_q]) begin
            ack_c  = grant_q & req;
            wea_d  = 1'b1;
            addr_d = addr_arr[ptr_q];
            data_d = data_arr[ptr_q];
            cnt_d  = cnt_inc;
            burst_end = req_last[ptr_q] || (cnt_inc == CNT_W'(MAX_BURST));
          end else begin
            burst_end = 1'b1;
          end
          if (burst_end) begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        CLEAR: begin
          wea_d  = 1'b1;
          addr_d = clr_addr_q;
          data_d = '0;
          if (clr_addr_q == ADDR_W'(TILE_COUNT - 1)) begin
            clr_addr_d = '0;
            pend_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      cnt_q      <= '0;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_c;
  assign clear_busy  = pend_q;
  assign bg_ram_addr = addr_q;
  assign bg_ram_data = data_q;
  assign bg_wea      = wea_q;

endmodule

// File: tb/tb_bg_write_arbiter.sv
// Scoreboard bench for bg_write_arbiter: accepted beats and clear writes are
// queued as expected RAM writes and popped when bg_wea is observed.
module tb_bg_write_arbiter;

  localparam int unsigned N  = 6;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TC = 1200;
  localparam int unsigned MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, en, clear_start;
  logic [N-1:0]    req, req_last, grant, ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            clear_busy, bg_wea;
  logic [AW-1:0]   bg_ram_addr;
  logic [DW-1:0]   bg_ram_data;

  bg_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TILE_COUNT(TC), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_last    (req_last),
    .clear_start (clear_start),
    .grant       (grant),
    .ack         (ack),
    .clear_busy  (clear_busy),
    .bg_ram_addr (bg_ram_addr),
    .bg_ram_data (bg_ram_data),
    .bg_wea      (bg_wea)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t       sb[$];
  logic [N-1:0] gseq[$];
  int         gcyc[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         clr_wr_cnt = 0;
  int         busy_gaps = 0;
  logic       last_clr_busy = 1'b1;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Push accepted beats, pop and compare every RAM write, log grant rises.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        if (ack[k]) sb.push_back('{a: req_addr[k*AW +: AW], d: req_data[k*DW +: DW], c: cyc});
      end
      if (bg_wea) begin
        if (sb.size() == 0) begin
          check("wr_unexpected", 64'(bg_ram_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 64'(bg_ram_addr), 64'(e.a));
          check("wr_data", 64'(bg_ram_data), 64'(e.d));
          if (e.c >= 0) begin
            check("wr_latency", 64'(cyc - e.c), 64'd1);
          end else begin
            clr_wr_cnt++;
            last_clr_busy = clear_busy;
            if ((bg_ram_addr != AW'(TC - 1)) && !clear_busy) busy_gaps++;
          end
          wr_cnt++;
        end
      end
      if ((grant != '0) && (prev_grant == '0)) begin
        gseq.push_back(grant);
        gcyc.push_back(cyc);
      end
      prev_grant = grant;
    end
  end

  task automatic set_beat(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
    req_last[k]          = l;
    req[k]               = 1'b1;
  endtask

  task automatic drive_burst(input int r, input int n, input logic [AW-1:0] base,
                             input bit mark_last, output int lat);
    int start;
    int guard;
    start = cyc;
    lat   = -1;
    for (int b = 0; b < n; b++) begin
      set_beat(r, base + AW'(b), {8'(r) + 8'hA0, 8'h5C, base + AW'(b)}, mark_last && (b == n - 1));
      guard = 0;
      @(negedge clk);
      while (!ack[r] && guard < 200) begin
        guard++;
        @(negedge clk);
      end
      if (!ack[r]) begin
        check("ack_timeout", 64'd0, 64'd1);
        break;
      end
      if (b == 0) lat = cyc - start;
      @(posedge clk);
      #1;
    end
    req[r]      = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic push_clear();
    for (int i = 0; i < int'(TC); i++) sb.push_back('{a: AW'(i), d: '0, c: -1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, guard, n3, last3, g4, w0, c0, ack_in_clr, f, fa, fw, fg, acks;
    logic [N-1:0] exp_rr [6];
    exp_rr = '{6'b000001, 6'b000100, 6'b100000, 6'b000001, 6'b000100, 6'b100000};

    reset = 1'b0; en = 1'b1; clear_start = 1'b0;
    req = '0; req_last = '0; req_addr = '0; req_data = '0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_wea", 64'(bg_wea), 64'd0);
    check("rst_busy", 64'(clear_busy), 64'd0);
    check("rst_addr", 64'(bg_ram_addr), 64'd0);
    check("rst_data", 64'(bg_ram_data), 64'd0);
    #21 reset = 1'b1;
    @(posedge clk); #1;

    // Round-robin among 0, 2, 5 with single-beat bursts
    gseq.delete(); gcyc.delete();
    set_beat(0, 16'h0100, 32'hC0DE_0000, 1'b1);
    set_beat(2, 16'h0102, 32'hC0DE_0002, 1'b1);
    set_beat(5, 16'h0105, 32'hC0DE_0005, 1'b1);
    guard = 0;
    while (gseq.size() < 6 && guard < 60) begin
      @(negedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req = '0; req_last = '0;
    check("rr_count", 64'(gseq.size()), 64'd6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) check("rr_order", 64'(gseq[i]), 64'(exp_rr[i]));
    for (int i = 1; i < 6 && i < gseq.size(); i++) check("rr_bubble", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
    repeat (3) @(posedge clk);
    #1 check("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Forced release: 3 streams without last, 4 waits
    set_beat(3, 16'h0300, 32'h3333_0300, 1'b0);
    set_beat(4, 16'h0400, 32'h4444_0400, 1'b1);
    n3 = 0; last3 = -1; g4 = -1; guard = 0;
    while (g4 < 0 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (ack[3]) begin n3++; last3 = cyc; end
      if (grant == 6'b010000) begin
        g4 = cyc;
        check("fr_ack4", 64'(ack), 64'h10);
      end
    end
    @(posedge clk); #1;
    req = '0; req_last = '0;
    check("fr_acks", 64'(n3), 64'(MB));
    check("fr_gap", 64'(g4 - last3), 64'd2);
    repeat (3) @(posedge clk);
    #1 check("fr_sb_empty", 64'(sb.size()), 64'd0);

    // Single 4-beat burst on requester 1
    gseq.delete(); gcyc.delete();
    w0 = wr_cnt;
    drive_burst(1, 4, 16'h0438, 1'b1, lat);
    check("sb_lat", 64'(lat), 64'd1);
    check("sb_grant", 64'((gseq.size() > 0) ? gseq[0] : '0), 64'b000010);
    @(negedge clk); #1;
    check("sb_release", 64'(grant), 64'd0);
    check("sb_writes", 64'(wr_cnt - w0), 64'd4);

    // Clear requested during beat 2 of a 5-beat burst
    fork
      drive_burst(0, 5, 16'h0800, 1'b1, lat);
      begin
        guard = 0;
        @(negedge clk);
        while (!ack[0] && guard < 20) begin guard++; @(negedge clk); end
        @(posedge clk); #1 clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
      end
    join
    check("clr_busy_set", 64'(clear_busy), 64'd1);
    c0 = clr_wr_cnt; busy_gaps = 0;
    push_clear();
    set_beat(2, 16'h0222, 32'h2222_0222, 1'b1);
    ack_in_clr = 0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (clear_busy && ack != '0) ack_in_clr++;
    end while (clear_busy && guard < 1400);
    f = cyc;
    #1;
    check("clr_no_ack", 64'(ack_in_clr), 64'd0);
    check("clr_writes", 64'(clr_wr_cnt - c0), 64'(TC));
    check("clr_busy_hold", 64'(busy_gaps), 64'd0);
    check("clr_busy_fall", 64'(last_clr_busy), 64'd0);
    guard = 0;
    @(negedge clk);
    while (!ack[2] && guard < 20) begin guard++; @(negedge clk); end
    check("clr_post_lat", 64'(cyc - f), 64'd1);
    @(posedge clk); #1;
    req = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1 check("clr_sb_empty", 64'(sb.size()), 64'd0);

    // Freeze mid-burst: 8 beats without last must still release at MAX_BURST
    fork
      drive_burst(0, 8, 16'h0900, 1'b0, lat);
      begin
        acks = 0; guard = 0;
        while (acks < 3 && guard < 40) begin
          @(negedge clk);
          guard++;
          if (ack[0]) acks++;
        end
        @(posedge clk); #1 en = 1'b0;
        fa = 0; fw = 0; fg = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (ack != '0) fa++;
          if (i > 0 && bg_wea) fw++;
          if (grant != 6'b000001) fg++;
        end
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);
        if (bg_wea) fw++;
      end
    join
    check("fz_ack", 64'(fa), 64'd0);
    check("fz_wea", 64'(fw), 64'd0);
    check("fz_owner", 64'(fg), 64'd0);
    @(negedge clk); #1;
    check("fz_release", 64'(grant), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("fz_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a clear
    @(posedge clk); #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    push_clear();
    guard = 0;
    @(negedge clk);
    while (!(bg_wea && bg_ram_addr == 16'd500) && guard < 700) begin guard++; @(negedge clk); end
    check("ar_reached", 64'(bg_ram_addr), 64'd500);
    #1 reset = 1'b0;
    #1;
    check("ar_wea", 64'(bg_wea), 64'd0);
    check("ar_grant", 64'(grant), 64'd0);
    check("ar_busy", 64'(clear_busy), 64'd0);
    check("ar_addr", 64'(bg_ram_addr), 64'd0);
    sb.delete();
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    set_beat(0, 16'h00A0, 32'hAAAA_00A0, 1'b1);
    set_beat(1, 16'h00A1, 32'hAAAA_00A1, 1'b1);
    guard = 0;
    @(negedge clk);
    while (grant == '0 && guard < 10) begin guard++; @(negedge clk); end
    check("ar_first", 64'(grant), 64'b000001);
    check("ar_busy_idle", 64'(clear_busy), 64'd0);
    @(posedge clk); #1 req[0] = 1'b0; req_last[0] = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!ack[1] && guard < 10) begin guard++; @(negedge clk); end
    check("ar_second", 64'(grant), 64'b000010);
    @(posedge clk); #1 req = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1 check("ar_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_write_arbiter.md
# bg_write_arbiter

Shares the single background tile-RAM write port among the game engine's tile writers: score digits, floor/cliff strip, coin, ghost, game-over text and future sprites. Requesters issue bursts of address/data beats; the block grants one owner at a time by round-robin, registers the winning beat onto the RAM port, and owns a built-in clear engine that zero-fills the whole tile map ahead of any requester. It replaces ad-hoc `bam_select` counter sequencing and sits between the engine's tile writers and the background RAM.

## Interface
- `N_REQ`, 6: number of requesters.
- `ADDR_W`, 16: tile RAM address width.
- `DATA_W`, 32: tile RAM data width.
- `TILE_COUNT`, 1200: entries zeroed by a clear (40×30).
- `MAX_BURST`, 256: beats before forced release.

Ports:
- `clk`, in, 1: system clock, all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: engine enable (`game_on`); 0 freezes state and suppresses writes.
- `req`, in, N_REQ: per-requester beat valid.
- `req_addr`, in, N_REQ*ADDR_W: flattened beat addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_data`, in, N_REQ*DATA_W: flattened beat data, same layout.
- `req_last`, in, N_REQ: marks the final beat of a burst.
- `clear_start`, in, 1: single-cycle pulse requesting a full-map zero fill.
- `grant`, out, N_REQ: one-hot current owner, registered.
- `ack`, out, N_REQ: beat accepted this cycle; `ack = grant & req` when `en`=1.
- `clear_busy`, out, 1: clear pending or running.
- `bg_ram_addr`, out, ADDR_W: RAM write address, registered.
- `bg_ram_data`, out, DATA_W: RAM write data, registered.
- `bg_wea`, out, 1: RAM write enable, registered.

## Operation
- States: IDLE, GRANT, CLEAR.
- Reset values: state IDLE, `grant`=0, `bg_wea`=0, `bg_ram_addr`=0, `bg_ram_data`=0, `clear_busy`=0, RR pointer `N_REQ-1` (requester 0 wins first), burst count 0, clear address 0, clear-pending flag 0.
- IDLE
  - Clear pending goes to CLEAR.
  - Otherwise, any `req` bit set: pick the first set bit searching upward from pointer+1 with wrap. Load one-hot `grant`, set pointer to the winner, go to GRANT.
- GRANT
  - Each cycle with `req[k]`=1 is a beat: `ack[k]`=1 and the burst count increments.
  - Burst ends on a beat with `req_last[k]`=1, on `req[k]`=0, or when the burst count reaches `MAX_BURST`.
  - At burst end: `grant`←0, count←0, state IDLE.
- CLEAR
  - Writes data 0 at addresses 0 to TILE_COUNT-1, one per cycle; `ack`=0 for all requesters.
  - After address TILE_COUNT-1: clear-pending←0, clear address←0, state IDLE.
- `clear_start` handling
  - In IDLE or GRANT: sets clear-pending; `clear_busy`=1 from the next cycle. A burst in progress completes first.
  - During CLEAR: ignored; no restart.
- `en`=0: no beats accepted, `ack`=0, `bg_wea`=0. State, counters and pointer hold; `clear_start` is still captured.
- Widths: the clear counter is ADDR_W bits. The burst counter is clog2(MAX_BURST+1) bits. Address and data pass through unmodified.

## Timing
- Accepted beat in cycle t gives `bg_wea`=1 with the beat's addr/data in cycle t+1. Latency 1, throughput 1 beat/cycle within a burst.
- `grant` asserts the cycle after IDLE arbitrates, so the first `ack` comes 1 cycle after `req` rises from IDLE.
- Exactly one bubble cycle (IDLE) between consecutive bursts and between a burst and a clear.
- A clear takes TILE_COUNT+1 cycles from IDLE to `clear_busy` falling. `clear_busy` drops in the cycle after the last clear write is issued.
- Requesters hold `req_addr`/`req_data` stable while `req`=1 and not acked.
- An asynchronous reset in any state immediately forces all outputs to their reset values. A truncated burst or clear is not resumed.

## Structure
- Shared package `bg_arb_pkg`:
  - state enum `{IDLE, GRANT, CLEAR}`;
  - `TILE_COLS`=40, `TILE_ROWS`=30, `TILE_COUNT`=`TILE_COLS*TILE_ROWS`;
  - requester index constants `REQ_SCORE`=0, `REQ_GROUND`=1, `REQ_COIN`=2, `REQ_TEXT`=3, `REQ_GHOST`=4, `REQ_SPARE`=5.
- One sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the one-hot winner and its index. Parameterised by `N_REQ`.

## Test plan
- **Single burst:** reset, then `req[1]`=1 for 4 beats, `req_last` on beat 4, addrs 0x438–0x43B.
  - `grant`=0b000010 one cycle after `req` rises.
  - Then 4 consecutive `bg_wea` pulses at 0x438–0x43B, each 1 cycle after its `ack`.
  - Then `grant`=0.
- **Round-robin:** `req[0]`, `req[2]` and `req[5]` held high, single-beat bursts.
  - Grant order 0, 2, 5, 0, 2, 5, with one IDLE bubble between bursts.
- **Forced release:** `MAX_BURST`=8, `req[3]` held high with no `req_last`, `req[4]` also high.
  - Requester 3 gets exactly 8 acks.
  - `grant` then moves to 0b010000 after one bubble.
- **Clear mid-burst:** `clear_start` during beat 2 of a 5-beat burst on requester 0.
  - The burst finishes all 5 beats.
  - Then 1200 writes with data 0 at addrs 0–1199.
  - `clear_busy` is high for the whole interval.
  - No `ack` is issued during the clear.
- **Freeze:** drop `en` for 10 cycles in the middle of a burst.
  - `bg_wea`=0 and `ack`=0 throughout.
  - After `en` returns, the burst resumes with the same owner and the beat count is preserved.
- **Async reset:** assert `reset` low during CLEAR at address 500.
  - `bg_wea`, `grant` and `clear_busy` go to 0 without waiting for a clock edge.
  - After release, the first request from requester 0 is granted.
